// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op encoding shared by ALU control and the ALU share arbiter
package alu_pkg;

   localparam int ALU_OP_W = 4;

   // Codes 4'b0110 and 4'b1011 are unassigned and treated as illegal.
   typedef enum logic [ALU_OP_W-1:0] {
      ALU_AND   = 4'b0000,
      ALU_OR    = 4'b0001,
      ALU_ADD   = 4'b0010,
      ALU_XOR   = 4'b0011,
      ALU_SLL   = 4'b0100,
      ALU_SRL   = 4'b0101,
      ALU_SRA   = 4'b0111,
      ALU_SLT   = 4'b1000,
      ALU_SLTU  = 4'b1001,
      ALU_NOR   = 4'b1010,
      ALU_SUB   = 4'b1100,
      ALU_PASSA = 4'b1101,
      ALU_PASSB = 4'b1110,
      ALU_NAND  = 4'b1111
   } alu_op_t;

   // Op driven whenever the ALU is idle or the requested op is illegal.
   localparam alu_op_t ALU_OP_SUM = ALU_ADD;

   function automatic logic is_legal_alu_op(input logic [ALU_OP_W-1:0] op);
      return !((op == 4'b0110) || (op == 4'b1011));
   endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// rtl/alu_rr_arb2.sv - two-way round-robin / fixed-priority arbiter with last-grant state
module alu_rr_arb2 #(
   parameter int PRIORITY_MODE = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic elig0_i,
   input  logic elig1_i,
   output logic grant0_o,
   output logic grant1_o
);

   logic last_grant_q, last_grant_d;

   always_comb begin
      grant0_o     = 1'b0;
      grant1_o     = 1'b0;
      last_grant_d = last_grant_q;
      if (elig0_i && elig1_i) begin
         if ((PRIORITY_MODE == 1) || last_grant_q) begin
            grant0_o = 1'b1;
         end else begin
            grant1_o = 1'b1;
         end
      end else begin
         grant0_o = elig0_i;
         grant1_o = elig1_i;
      end
      if (grant0_o) begin
         last_grant_d = 1'b0;
      end else if (grant1_o) begin
         last_grant_d = 1'b1;
      end
   end

   // Reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one ALU between core execute and aux unit, with response regs
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int TAG_WIDTH     = 4,
   parameter int PRIORITY_MODE = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid_i,
   output logic                  req0_ready_o,
   input  logic [ALU_OP_W-1:0]   req0_op_i,
   input  logic [DATA_WIDTH-1:0] req0_a_i,
   input  logic [DATA_WIDTH-1:0] req0_b_i,
   input  logic [TAG_WIDTH-1:0]  req0_tag_i,
   input  logic                  req1_valid_i,
   output logic                  req1_ready_o,
   input  logic [ALU_OP_W-1:0]   req1_op_i,
   input  logic [DATA_WIDTH-1:0] req1_a_i,
   input  logic [DATA_WIDTH-1:0] req1_b_i,
   input  logic [TAG_WIDTH-1:0]  req1_tag_i,
   output logic                  rsp0_valid_o,
   input  logic                  rsp0_ready_i,
   output logic [DATA_WIDTH-1:0] rsp0_result_o,
   output logic                  rsp0_zero_o,
   output logic                  rsp0_err_o,
   output logic [TAG_WIDTH-1:0]  rsp0_tag_o,
   output logic                  rsp1_valid_o,
   input  logic                  rsp1_ready_i,
   output logic [DATA_WIDTH-1:0] rsp1_result_o,
   output logic                  rsp1_zero_o,
   output logic                  rsp1_err_o,
   output logic [TAG_WIDTH-1:0]  rsp1_tag_o,
   output logic [ALU_OP_W-1:0]   alu_op_o,
   output logic [DATA_WIDTH-1:0] alu_a_o,
   output logic [DATA_WIDTH-1:0] alu_b_o,
   input  logic [DATA_WIDTH-1:0] alu_result_i,
   input  logic                  alu_zero_i,
   output logic                  busy_o
);

   logic [1:0]                 elig, grant, rsp_ready;
   logic [1:0]                 rsp_valid_q, rsp_valid_d;
   logic [1:0][DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [1:0]                 rsp_zero_q, rsp_zero_d;
   logic [1:0]                 rsp_err_q, rsp_err_d;
   logic [1:0][TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;

   logic [ALU_OP_W-1:0]   sel_op;
   logic [DATA_WIDTH-1:0] sel_a, sel_b;
   logic [TAG_WIDTH-1:0]  sel_tag;
   logic                  op_legal;

   assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};

   // A slot being drained this cycle counts as free; no grants while in reset.
   always_comb begin
      elig[0] = rst_n && req0_valid_i && (!rsp_valid_q[0] || rsp0_ready_i);
      elig[1] = rst_n && req1_valid_i && (!rsp_valid_q[1] || rsp1_ready_i);
   end

   alu_rr_arb2 #(
      .PRIORITY_MODE(PRIORITY_MODE)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .elig0_i (elig[0]),
      .elig1_i (elig[1]),
      .grant0_o(grant[0]),
      .grant1_o(grant[1])
   );

   always_comb begin
      sel_op   = grant[1] ? req1_op_i  : req0_op_i;
      sel_a    = grant[1] ? req1_a_i   : req0_a_i;
      sel_b    = grant[1] ? req1_b_i   : req0_b_i;
      sel_tag  = grant[1] ? req1_tag_i : req0_tag_i;
      op_legal = is_legal_alu_op(sel_op);

      alu_op_o = ALU_OP_SUM;
      alu_a_o  = '0;
      alu_b_o  = '0;
      if (|grant) begin
         alu_op_o = op_legal ? sel_op : ALU_OP_SUM;
         alu_a_o  = sel_a;
         alu_b_o  = sel_b;
      end
   end

   // Only one grant per cycle, so both slots can load from the same captured ALU output.
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      rsp_tag_d    = rsp_tag_q;
      for (int i = 0; i < 2; i++) begin
         if (grant[i]) begin
            rsp_valid_d[i]  = 1'b1;
            rsp_result_d[i] = op_legal ? alu_result_i : '0;
            rsp_zero_d[i]   = op_legal && alu_zero_i;
            rsp_err_d[i]    = !op_legal;
            rsp_tag_d[i]    = sel_tag;
         end else if (rsp_ready[i]) begin
            rsp_valid_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= '0;
         rsp_err_q    <= '0;
         rsp_tag_q    <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         rsp_tag_q    <= rsp_tag_d;
      end
   end

   assign req0_ready_o  = grant[0];
   assign req1_ready_o  = grant[1];
   assign rsp0_valid_o  = rsp_valid_q[0];
   assign rsp0_result_o = rsp_result_q[0];
   assign rsp0_zero_o   = rsp_zero_q[0];
   assign rsp0_err_o    = rsp_err_q[0];
   assign rsp0_tag_o    = rsp_tag_q[0];
   assign rsp1_valid_o  = rsp_valid_q[1];
   assign rsp1_result_o = rsp_result_q[1];
   assign rsp1_zero_o   = rsp_zero_q[1];
   assign rsp1_err_o    = rsp_err_q[1];
   assign rsp1_tag_o    = rsp_tag_q[1];
   assign busy_o        = (|rsp_valid_q) || (|grant);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter (round-robin and fixed-priority)
module tb_alu_share_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req0_valid = 0, req1_valid = 0;
   logic [3:0]  req0_op = 0, req1_op = 0;
   logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [3:0]  req0_tag = 0, req1_tag = 0;
   logic        rsp0_ready = 0, rsp1_ready = 0;

   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [31:0] rsp0_result, rsp1_result;
   logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
   logic [3:0]  rsp0_tag, rsp1_tag;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_zero, busy;

   logic        p_req0_ready, p_req1_ready, p_rsp0_valid, p_rsp1_valid;
   logic [31:0] p_rsp0_result, p_rsp1_result;
   logic        p_rsp0_zero, p_rsp1_zero, p_rsp0_err, p_rsp1_err;
   logic [3:0]  p_rsp0_tag, p_rsp1_tag;
   logic [3:0]  p_alu_op;
   logic [31:0] p_alu_a, p_alu_b, p_alu_result;
   logic        p_alu_zero, p_busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        e;
      logic [3:0]  tag;
   } exp_t;
   exp_t q0[$], q1[$];

   logic [3:0] legal_ops [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7,
                                  4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE, 4'hF};

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'h0:    return a & b;
         4'h1:    return a | b;
         4'h2:    return a + b;
         4'h3:    return a ^ b;
         4'h4:    return a << b[4:0];
         4'h5:    return a >> b[4:0];
         4'h7:    return $unsigned($signed(a) >>> b[4:0]);
         4'h8:    return {31'd0, $signed(a) < $signed(b)};
         4'h9:    return {31'd0, a < b};
         4'hA:    return ~(a | b);
         4'hC:    return a - b;
         4'hD:    return a;
         4'hE:    return b;
         4'hF:    return ~(a & b);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] tag);
      exp_t r;
      r.tag = tag;
      if (op == 4'b0110 || op == 4'b1011) begin
         r.res = 0; r.z = 0; r.e = 1;
      end else begin
         r.res = alu_f(op, a, b); r.z = (r.res == 0); r.e = 0;
      end
      return r;
   endfunction

   assign alu_result   = alu_f(alu_op, alu_a, alu_b);
   assign alu_zero     = (alu_result == 0);
   assign p_alu_result = alu_f(p_alu_op, p_alu_a, p_alu_b);
   assign p_alu_zero   = (p_alu_result == 0);

   alu_share_arbiter #(.DATA_WIDTH(32), .TAG_WIDTH(4), .PRIORITY_MODE(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
      .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_tag_i(req0_tag),
      .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
      .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_tag_i(req1_tag),
      .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_result_o(rsp0_result),
      .rsp0_zero_o(rsp0_zero), .rsp0_err_o(rsp0_err), .rsp0_tag_o(rsp0_tag),
      .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_result_o(rsp1_result),
      .rsp1_zero_o(rsp1_zero), .rsp1_err_o(rsp1_err), .rsp1_tag_o(rsp1_tag),
      .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
      .alu_result_i(alu_result), .alu_zero_i(alu_zero), .busy_o(busy)
   );

   alu_share_arbiter #(.DATA_WIDTH(32), .TAG_WIDTH(4), .PRIORITY_MODE(1)) dut_prio (
      .clk(clk), .rst_n(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(p_req0_ready), .req0_op_i(req0_op),
      .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_tag_i(req0_tag),
      .req1_valid_i(req1_valid), .req1_ready_o(p_req1_ready), .req1_op_i(req1_op),
      .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_tag_i(req1_tag),
      .rsp0_valid_o(p_rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_result_o(p_rsp0_result),
      .rsp0_zero_o(p_rsp0_zero), .rsp0_err_o(p_rsp0_err), .rsp0_tag_o(p_rsp0_tag),
      .rsp1_valid_o(p_rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_result_o(p_rsp1_result),
      .rsp1_zero_o(p_rsp1_zero), .rsp1_err_o(p_rsp1_err), .rsp1_tag_o(p_rsp1_tag),
      .alu_op_o(p_alu_op), .alu_a_o(p_alu_a), .alu_b_o(p_alu_b),
      .alu_result_i(p_alu_result), .alu_zero_i(p_alu_zero), .busy_o(p_busy)
   );

   // Scoreboard on the round-robin instance: push on grant, pop on response consumption.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q0.delete();
         q1.delete();
      end else begin
         if (rsp0_valid && rsp0_ready) begin
            checks++;
            if (q0.size() == 0) begin
               errors++;
               $display("FAIL sb0_unexpected: got result=%h tag=%h, required no response", rsp0_result, rsp0_tag);
            end else begin
               e = q0.pop_front();
               if ({rsp0_result, rsp0_zero, rsp0_err, rsp0_tag} !== {e.res, e.z, e.e, e.tag}) begin
                  errors++;
                  $display("FAIL sb0_rsp: got res=%h z=%b err=%b tag=%h, required res=%h z=%b err=%b tag=%h",
                           rsp0_result, rsp0_zero, rsp0_err, rsp0_tag, e.res, e.z, e.e, e.tag);
               end
            end
         end
         if (rsp1_valid && rsp1_ready) begin
            checks++;
            if (q1.size() == 0) begin
               errors++;
               $display("FAIL sb1_unexpected: got result=%h tag=%h, required no response", rsp1_result, rsp1_tag);
            end else begin
               e = q1.pop_front();
               if ({rsp1_result, rsp1_zero, rsp1_err, rsp1_tag} !== {e.res, e.z, e.e, e.tag}) begin
                  errors++;
                  $display("FAIL sb1_rsp: got res=%h z=%b err=%b tag=%h, required res=%h z=%b err=%b tag=%h",
                           rsp1_result, rsp1_zero, rsp1_err, rsp1_tag, e.res, e.z, e.e, e.tag);
               end
            end
         end
         if (req0_ready) q0.push_back(model(req0_op, req0_a, req0_b, req0_tag));
         if (req1_ready) q1.push_back(model(req1_op, req1_a, req1_b, req1_tag));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      req0_valid = 1; req0_op = 4'h2; req0_a = 1; req0_b = 2; req0_tag = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy0=%b rdy1=%b v0=%b v1=%b busy=%b, required all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy);
         end
         checks++;
         if (alu_op !== 4'b0010 || alu_a !== 0 || alu_b !== 0) begin
            errors++;
            $display("FAIL reset_alu: got op=%b a=%h b=%h, required op=0010 a=0 b=0", alu_op, alu_a, alu_b);
         end
         tick();
      end
      req0_valid = 0;
      rst_n = 1;
      tick();
   endtask

   task automatic test_single();
      rsp0_ready = 1; rsp1_ready = 1;
      req0_valid = 1; req0_op = 4'h2; req0_a = 5; req0_b = 7; req0_tag = 3;
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_ready: got %b, required 1", req0_ready);
      end
      tick();
      req0_valid = 0;
      @(negedge clk);
      checks++;
      if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_tag} !== {1'b1, 32'd12, 1'b0, 4'd3}) begin
         errors++;
         $display("FAIL single_rsp: got v=%b res=%0d z=%b tag=%0d, required v=1 res=12 z=0 tag=3",
                  rsp0_valid, rsp0_result, rsp0_zero, rsp0_tag);
      end
      tick();
   endtask

   task automatic test_rr();
      int exp_g = 1;
      req0_valid = 1; req1_valid = 1;
      for (int i = 0; i < 8; i++) begin
         req0_op = legal_ops[$urandom_range(13)]; req0_a = $urandom; req0_b = $urandom; req0_tag = 4'($urandom);
         req1_op = legal_ops[$urandom_range(13)]; req1_a = $urandom; req1_b = $urandom; req1_tag = 4'($urandom);
         @(negedge clk);
         checks++;
         if (req0_ready !== (exp_g == 0) || req1_ready !== (exp_g == 1)) begin
            errors++;
            $display("FAIL rr_grant[%0d]: got rdy0=%b rdy1=%b, required grant to req%0d", i, req0_ready, req1_ready, exp_g);
         end
         checks++;
         if (p_req0_ready !== 1'b1 || p_req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_grant[%0d]: got rdy0=%b rdy1=%b, required rdy0=1 rdy1=0", i, p_req0_ready, p_req1_ready);
         end
         tick();
         exp_g = 1 - exp_g;
      end
      req0_valid = 0; req1_valid = 0;
      tick();
   endtask

   task automatic test_hold();
      exp_t held;
      rsp1_ready = 0;
      req1_valid = 1; req1_op = 4'h3; req1_a = 32'hF0; req1_b = 32'h0F; req1_tag = 6;
      held = model(req1_op, req1_a, req1_b, req1_tag);
      @(negedge clk);
      checks++;
      if (req1_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_first_ready: got %b, required 1", req1_ready);
      end
      tick();
      req1_op = 4'h2; req1_a = 100; req1_b = 23; req1_tag = 9;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({req1_ready, rsp1_valid, rsp1_result, rsp1_tag} !== {1'b0, 1'b1, held.res, held.tag}) begin
            errors++;
            $display("FAIL hold_stable[%0d]: got rdy=%b v=%b res=%h tag=%h, required rdy=0 v=1 res=%h tag=%h",
                     i, req1_ready, rsp1_valid, rsp1_result, rsp1_tag, held.res, held.tag);
         end
         tick();
      end
      rsp1_ready = 1;
      @(negedge clk);
      checks++;
      if (req1_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_regrant: got %b, required 1", req1_ready);
      end
      tick();
      req1_valid = 0;
      @(negedge clk);
      checks++;
      if ({rsp1_valid, rsp1_result, rsp1_tag} !== {1'b1, 32'd123, 4'd9}) begin
         errors++;
         $display("FAIL hold_new: got v=%b res=%0d tag=%0d, required v=1 res=123 tag=9", rsp1_valid, rsp1_result, rsp1_tag);
      end
      tick();
   endtask

   task automatic test_flags();
      rsp0_ready = 1; rsp1_ready = 1;
      req0_valid = 1; req0_op = 4'hC; req0_a = 9; req0_b = 9; req0_tag = 5;
      tick();
      req0_valid = 0;
      @(negedge clk);
      checks++;
      if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sub_zero: got v=%b res=%h z=%b err=%b, required v=1 res=0 z=1 err=0",
                  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err);
      end
      tick();
      req1_valid = 1; req1_op = 4'b0110; req1_a = 3; req1_b = 4; req1_tag = 2;
      @(negedge clk);
      checks++;
      if (req1_ready !== 1'b1 || alu_op !== 4'b0010) begin
         errors++;
         $display("FAIL illegal_drive: got rdy=%b alu_op=%b, required rdy=1 alu_op=0010", req1_ready, alu_op);
      end
      tick();
      req1_valid = 0;
      req0_valid = 1; req0_op = 4'b1011; req0_a = 1; req0_b = 1; req0_tag = 7;
      @(negedge clk);
      checks++;
      if ({rsp1_valid, rsp1_err, rsp1_result, rsp1_zero, rsp1_tag} !== {1'b1, 1'b1, 32'd0, 1'b0, 4'd2}) begin
         errors++;
         $display("FAIL illegal_rsp: got v=%b err=%b res=%h z=%b tag=%0d, required v=1 err=1 res=0 z=0 tag=2",
                  rsp1_valid, rsp1_err, rsp1_result, rsp1_zero, rsp1_tag);
      end
      tick();
      req0_valid = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      rsp0_ready = 0; rsp1_ready = 0;
      req1_valid = 1; req1_op = 4'h2; req1_a = 1; req1_b = 1; req1_tag = 1;
      tick();
      req1_valid = 0;
      req0_valid = 1; req0_op = 4'h1; req0_a = 2; req0_b = 4; req0_tag = 4;
      tick();
      req0_valid = 0;
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_full: got v0=%b v1=%b, required both 1", rsp0_valid, rsp1_valid);
      end
      tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got v0=%b v1=%b busy=%b, required all 0", rsp0_valid, rsp1_valid, busy);
      end
      tick();
      rsp0_ready = 1; rsp1_ready = 1;
      req0_valid = 1; req1_valid = 1;
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_tie: got rdy0=%b rdy1=%b, required rdy0=1 rdy1=0", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 0; req1_valid = 0;
   endtask

   task automatic test_drain();
      rsp0_ready = 1; rsp1_ready = 1;
      for (int i = 0; i < 3; i++) tick();
      @(negedge clk);
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain: got pending q0=%0d q1=%0d, required 0 and 0", q0.size(), q1.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_rr();
      test_hold();
      test_flags();
      test_reset_mid();
      test_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
